// File: rtl/cache_manage_unit.sv
// Request controller for a 2-way write-back cache: issue, dirty-victim write-back, line refill, retry.
// Optional hit/miss statistics counters are enabled by defining CACHE_STAT_EN.
module cache_manage_unit #(
   parameter int ADDR_BITS           = 32,
   parameter int TAG_BITS            = 23,
   parameter int SET_INDEX_WIDTH     = 5,
   parameter int ELEMENT_WORDS_WIDTH = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cpu_req_valid,
   input  logic                 cpu_req_wen,
   input  logic [ADDR_BITS-1:0] cpu_req_addr,
   input  logic [2:0]           cpu_req_ubhw,
   input  logic [31:0]          cpu_req_data,
   output logic [31:0]          cpu_result,
   output logic                 cpu_ready,
   output logic [ADDR_BITS-1:0] cache_addr,
   output logic                 cache_load,
   output logic                 cache_edit,
   output logic                 cache_store,
   output logic                 cache_invalid,
   output logic [2:0]           cache_ubhw,
   output logic [31:0]          cache_din,
   input  logic                 cache_hit,
   input  logic [31:0]          cache_dout,
   input  logic                 cache_valid,
   input  logic                 cache_dirty,
   input  logic [TAG_BITS-1:0]  cache_tag,
   output logic                 mem_cs,
   output logic                 mem_we,
   output logic [ADDR_BITS-1:0] mem_addr,
   output logic [31:0]          mem_wdata,
   input  logic [31:0]          mem_rdata,
   input  logic                 mem_ack
`ifdef CACHE_STAT_EN
   ,
   output logic [31:0]          hit_cnt,
   output logic [31:0]          miss_cnt
`endif
);

   localparam int OFF_BITS = ELEMENT_WORDS_WIDTH + 2;

   typedef enum logic [2:0] {
      S_IDLE, S_CHECK, S_BACK_RD, S_BACK_WR, S_FILL, S_RETRY, S_REISSUE
   } state_t;

   state_t                         r_state;
   logic [ELEMENT_WORDS_WIDTH-1:0] r_word_cnt;
   logic [ADDR_BITS-1:0]           r_addr;
   logic                           r_wen;
   logic [2:0]                     r_ubhw;
   logic [31:0]                    r_data;
   logic [TAG_BITS-1:0]            r_victim_tag;
   logic [31:0]                    r_wbuf;
   logic                           r_wb_first;

   logic                           w_req;
   logic                           w_last_word;
   logic [TAG_BITS-1:0]            w_req_tag;
   logic [SET_INDEX_WIDTH-1:0]     w_req_idx;
   logic [ADDR_BITS-1:0]           w_line_addr;
   logic [ADDR_BITS-1:0]           w_back_addr;

   // Gating with rst keeps the combinational IDLE strobes quiet while reset is held.
   assign w_req       = cpu_req_valid & rst;
   assign w_last_word = (r_word_cnt == {ELEMENT_WORDS_WIDTH{1'b1}});
   assign w_req_tag   = r_addr[ADDR_BITS-1 -: TAG_BITS];
   assign w_req_idx   = r_addr[OFF_BITS +: SET_INDEX_WIDTH];
   assign w_line_addr = {w_req_tag, w_req_idx, r_word_cnt, 2'b00};
   assign w_back_addr = {r_victim_tag, w_req_idx, r_word_cnt, 2'b00};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_word_cnt   <= '0;
         r_addr       <= '0;
         r_wen        <= 1'b0;
         r_ubhw       <= '0;
         r_data       <= '0;
         r_victim_tag <= '0;
         r_wbuf       <= '0;
         r_wb_first   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (cpu_req_valid) begin
                  r_addr  <= cpu_req_addr;
                  r_wen   <= cpu_req_wen;
                  r_ubhw  <= cpu_req_ubhw;
                  r_data  <= cpu_req_data;
                  r_state <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (cache_hit) begin
                  r_state <= S_IDLE;
               end else begin
                  r_victim_tag <= cache_tag;
                  r_word_cnt   <= '0;
                  r_state      <= (cache_valid && cache_dirty) ? S_BACK_RD : S_FILL;
               end
            end
            S_BACK_RD: begin
               r_wb_first <= 1'b1;
               r_state    <= S_BACK_WR;
            end
            S_BACK_WR: begin
               // The victim word is on cache_dout only in the first write-back cycle.
               if (r_wb_first) begin
                  r_wbuf     <= cache_dout;
                  r_wb_first <= 1'b0;
               end
               if (mem_ack) begin
                  r_word_cnt <= r_word_cnt + 1'b1;
                  r_state    <= w_last_word ? S_FILL : S_BACK_RD;
               end
            end
            S_FILL: begin
               if (mem_ack) begin
                  r_word_cnt <= r_word_cnt + 1'b1;
                  if (w_last_word) r_state <= S_RETRY;
               end
            end
            S_RETRY:   r_state <= S_REISSUE;
            S_REISSUE: r_state <= S_CHECK;
            default:   r_state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      cpu_result    = '0;
      cpu_ready     = 1'b0;
      cache_addr    = '0;
      cache_load    = 1'b0;
      cache_edit    = 1'b0;
      cache_store   = 1'b0;
      cache_invalid = 1'b0;
      cache_ubhw    = '0;
      cache_din     = '0;
      mem_cs        = 1'b0;
      mem_we        = 1'b0;
      mem_addr      = '0;
      mem_wdata     = '0;
      case (r_state)
         S_IDLE: begin
            if (w_req) begin
               cache_addr = cpu_req_addr;
               cache_load = ~cpu_req_wen;
               cache_edit = cpu_req_wen;
               cache_din  = cpu_req_data;
               cache_ubhw = cpu_req_ubhw;
            end
         end
         S_CHECK: begin
            if (cache_hit) begin
               cpu_ready  = 1'b1;
               cpu_result = r_wen ? 32'd0 : cache_dout;
            end
         end
         S_BACK_RD: cache_addr = w_line_addr;
         S_BACK_WR: begin
            mem_cs    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = w_back_addr;
            mem_wdata = r_wb_first ? cache_dout : r_wbuf;
         end
         S_FILL: begin
            mem_cs   = 1'b1;
            mem_addr = w_line_addr;
            if (mem_ack) begin
               cache_store = 1'b1;
               cache_din   = mem_rdata;
               cache_addr  = w_line_addr;
            end
         end
         S_REISSUE: begin
            cache_addr = r_addr;
            cache_load = ~r_wen;
            cache_edit = r_wen;
            cache_din  = r_data;
            cache_ubhw = r_ubhw;
         end
         default: ;
      endcase
   end

`ifdef CACHE_STAT_EN
   logic [31:0] r_hit_cnt;
   logic [31:0] r_miss_cnt;
   logic        r_from_idle;

   // Only the first lookup of a request is counted; the post-refill retry is not.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hit_cnt   <= '0;
         r_miss_cnt  <= '0;
         r_from_idle <= 1'b0;
      end else begin
         if (r_state == S_IDLE && cpu_req_valid) r_from_idle <= 1'b1;
         else if (r_state == S_REISSUE)          r_from_idle <= 1'b0;
         if (r_state == S_CHECK && r_from_idle) begin
            if (cache_hit) begin
               if (r_hit_cnt != 32'hFFFF_FFFF) r_hit_cnt <= r_hit_cnt + 32'd1;
            end else begin
               if (r_miss_cnt != 32'hFFFF_FFFF) r_miss_cnt <= r_miss_cnt + 32'd1;
            end
         end
      end
   end

   assign hit_cnt  = r_hit_cnt;
   assign miss_cnt = r_miss_cnt;
`endif

endmodule
